game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Top-level game sequencer for the snake game. It turns debounced key pulses and the collision pulse into a four-state game flow (IDLE/RUN/PAUSE/OVER). It drives the start/clear controls of the 0.1 s / seconds game timer and reads back the elapsed seconds. It also schedules the snake-move tick, whose period shortens as elapsed time raises the level.

Parameters:
MOVE_BASE, 25'd12_499_999, move-tick period in clocks at level 0 (0.25 s at 50 MHz)
MOVE_STEP, 25'd1_000_000, period reduction per level
LEVEL_SECS, 16'd10, seconds of play per level increment
MAX_LEVEL, 4'd8, level saturation value
TIME_LIMIT, 16'd300, seconds until timeout (used only with AUTO_TIMEOUT_EN)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  reset, synchronous, active-high
key_start  in  1  one-cycle pulse, start/pause toggle (already debounced)
key_restart  in  1  one-cycle pulse, return to IDLE
collision  in  1  one-cycle pulse from snake logic
time_s  in  16  elapsed seconds from game timer data output
timer_start  out  1  level enable to game timer start_signal
timer_clear  out  1  one-cycle pulse to game timer clear_signal
game_state  out  2  0=IDLE 1=RUN 2=PAUSE 3=OVER
level  out  4  current speed level
move_tick  out  1  one-cycle pulse: advance snake one cell

Behaviour:
- Reset (sys_rst=1 at a clock edge) forces the following, regardless of current state:
  - game_state=IDLE, level=0, timer_start=0, move_tick=0.
  - timer_clear=1 for exactly the cycle after reset deasserts, so the timer starts from 0.
  - Move counter=0, next_level_at=LEVEL_SECS.
- Event priority within one cycle: key_restart > (collision | timeout) > key_start.
- Transitions:
  - IDLE: key_start -> RUN.
  - RUN: key_restart -> IDLE; collision or timeout -> OVER; key_start -> PAUSE.
  - PAUSE: key_restart -> IDLE; key_start -> RUN; collision ignored.
  - OVER: key_restart -> IDLE; all else ignored.
- Any entry into IDLE:
  - timer_clear pulses 1 cycle, registered in the same edge as the state change.
  - level, move counter and next_level_at are reinitialised.
- timer_start is a registered output: it is 1 exactly while game_state==RUN. The timer therefore freezes in PAUSE and OVER and keeps its value for display.
- Move counter:
  - Increments only in RUN; holds in PAUSE.
  - period = MOVE_BASE - level*MOVE_STEP, computed combinationally in 25 bits. Defaults guarantee period > 0 at MAX_LEVEL.
  - When the counter reaches period, the counter goes to 0 and move_tick=1 for one cycle (registered).
  - No move_tick in any state other than RUN, including the cycle of a RUN->PAUSE/OVER transition.
- Level scheduling:
  - In RUN, when time_s == next_level_at and level < MAX_LEVEL: level increments and next_level_at += LEVEL_SECS.
  - At MAX_LEVEL, level holds.
  - A level change takes effect on the next counter comparison; the counter is not reset.
- Simultaneous key_start and collision in RUN -> OVER.
- Simultaneous key_restart and anything -> IDLE.
- Pulses arriving in a state with no matching transition are dropped, not queued.

Optional Feature:
AUTO_TIMEOUT_EN:
- Defined: timeout = (game_state==RUN && time_s >= TIME_LIMIT), which moves the game to OVER.
- Undefined: timeout is tied to 0, so the game only ends on collision and TIME_LIMIT is unused.

Decomposition:
- Package game_pkg holds:
  - state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_OVER (2-bit localparams);
  - the level and period widths.
- One natural sub-module, move_tick_gen: the programmable-period counter.
  - Inputs: enable, period, clear.
  - Output: tick.
- The FSM and level logic stay in game_flow_ctrl.

Test Plan:
1. Reset then key_start -> game_state 0->1 next edge; timer_start=1 one cycle later; timer_clear pulsed once after reset.
2. RUN with MOVE_BASE overridden to 9 -> move_tick every 10 clocks. key_start -> PAUSE: no ticks, timer_start=0. key_start again -> ticks resume with counter phase preserved.
3. Drive time_s 9,10,...,90 in RUN, LEVEL_SECS=10 -> level increments at 10,20,...,80 and saturates at 8. Tick period shrinks by MOVE_STEP per level.
4. key_start and collision in the same RUN cycle -> OVER, not PAUSE. Further key_start is ignored. key_restart -> IDLE with a one-cycle timer_clear and level=0.
5. AUTO_TIMEOUT_EN defined, time_s=300 in RUN -> OVER next edge. Undefined, same stimulus -> stays RUN.
6. sys_rst asserted mid-RUN at level 5 -> next edge: IDLE, level=0, move_tick=0, timer_start=0.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared encodings and widths for the snake game flow controller
package game_pkg;

  localparam int LEVEL_W  = 4;
  localparam int PERIOD_W = 25;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

endpackage

// File: rtl/move_tick_gen.sv
// rtl/move_tick_gen.sv - programmable-period counter producing the snake move tick
// Ports:
//   sys_clk  clock
//   clear    synchronous clear of counter and tick (reset or return to IDLE)
//   enable   count only while the game is running
//   period   terminal count; one tick every period+1 enabled clocks
//   tick     registered one-cycle pulse
import game_pkg::*;

module move_tick_gen (
  input  logic                sys_clk,
  input  logic                clear,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;

  always_ff @(posedge sys_clk) begin
    if (clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (enable) begin
      // >= rather than == so a level-up that shrinks period below the
      // current count wraps on the next comparison instead of running away.
      if (count >= period) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + 1'b1;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - snake game sequencer: IDLE/RUN/PAUSE/OVER, timer control, level and move tick
// Optional feature macro: AUTO_TIMEOUT_EN (game ends when time_s reaches TIME_LIMIT in RUN)
// Ports:
//   sys_clk      50 MHz clock
//   sys_rst      synchronous active-high reset
//   key_start    start/pause toggle pulse
//   key_restart  return-to-IDLE pulse
//   collision    collision pulse from snake logic
//   time_s       elapsed seconds from game timer
//   timer_start  game timer run enable
//   timer_clear  one-cycle game timer clear
//   game_state   0=IDLE 1=RUN 2=PAUSE 3=OVER
//   level        current speed level
//   move_tick    one-cycle snake advance pulse
import game_pkg::*;

module game_flow_ctrl #(
  parameter logic [PERIOD_W-1:0] MOVE_BASE  = 25'd12_499_999,
  parameter logic [PERIOD_W-1:0] MOVE_STEP  = 25'd1_000_000,
  parameter logic [15:0]         LEVEL_SECS = 16'd10,
  parameter logic [LEVEL_W-1:0]  MAX_LEVEL  = 4'd8,
  parameter logic [15:0]         TIME_LIMIT = 16'd300
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               key_start,
  input  logic               key_restart,
  input  logic               collision,
  input  logic [15:0]        time_s,
  output logic               timer_start,
  output logic               timer_clear,
  output logic [1:0]         game_state,
  output logic [LEVEL_W-1:0] level,
  output logic               move_tick
);

  logic [1:0]          next_state;
  logic [15:0]         next_level_at;
  logic                rst_seen;
  logic                timeout;
  logic                idle_entry;
  logic                run_hold;
  logic                level_up;
  logic [PERIOD_W-1:0] period;

`ifdef AUTO_TIMEOUT_EN
  assign timeout = (game_state == ST_RUN) && (time_s >= TIME_LIMIT);
`else
  logic unused_time_limit;
  assign unused_time_limit = ^TIME_LIMIT;
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) game_state <= ST_IDLE;
    else         game_state <= next_state;
  end

  // Next-state logic; restart beats end-of-game beats start/pause
  always_comb begin
    next_state = game_state;
    case (game_state)
      ST_IDLE:  if (!key_restart && key_start) next_state = ST_RUN;
      ST_RUN: begin
        if (key_restart)              next_state = ST_IDLE;
        else if (collision || timeout) next_state = ST_OVER;
        else if (key_start)           next_state = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (key_restart)    next_state = ST_IDLE;
        else if (key_start) next_state = ST_RUN;
      end
      default:  if (key_restart) next_state = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    idle_entry = (game_state != ST_IDLE) && (next_state == ST_IDLE);
    // Counting only when staying in RUN keeps the exit edge tick-free.
    run_hold   = (game_state == ST_RUN) && (next_state == ST_RUN);
    level_up   = (game_state == ST_RUN) && (time_s == next_level_at) &&
                 (level < MAX_LEVEL);
    period     = MOVE_BASE - PERIOD_W'(level) * MOVE_STEP;
  end

  // Registered outputs and level bookkeeping
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      level         <= '0;
      next_level_at <= LEVEL_SECS;
      timer_start   <= 1'b0;
      timer_clear   <= 1'b0;
      rst_seen      <= 1'b1;
    end else begin
      rst_seen    <= 1'b0;
      // First cycle out of reset also clears the timer.
      timer_clear <= rst_seen | idle_entry;
      timer_start <= (next_state == ST_RUN);
      if (idle_entry) begin
        level         <= '0;
        next_level_at <= LEVEL_SECS;
      end else if (level_up) begin
        level         <= level + 1'b1;
        next_level_at <= next_level_at + LEVEL_SECS;
      end
    end
  end

  move_tick_gen u_move_tick_gen (
    .sys_clk (sys_clk),
    .clear   (sys_rst | idle_entry),
    .enable  (run_hold),
    .period  (period),
    .tick    (move_tick)
  );

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - scoreboard bench for game_flow_ctrl
module tb_game_flow_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        key_start = 1'b0;
  logic        key_restart = 1'b0;
  logic        collision = 1'b0;
  logic [15:0] time_s = 16'd0;
  logic        timer_start;
  logic        timer_clear;
  logic [1:0]  game_state;
  logic [3:0]  level;
  logic        move_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit sb_on = 1'b0;
  int exp_q[$];

  game_flow_ctrl #(
    .MOVE_BASE  (25'd9),
    .MOVE_STEP  (25'd1),
    .LEVEL_SECS (16'd10),
    .MAX_LEVEL  (4'd8),
    .TIME_LIMIT (16'd300)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_start   (key_start),
    .key_restart (key_restart),
    .collision   (collision),
    .time_s      (time_s),
    .timer_start (timer_start),
    .timer_clear (timer_clear),
    .game_state  (game_state),
    .level       (level),
    .move_tick   (move_tick)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock; sample 1 ns after the edge and retire scoreboard entries.
  task automatic step();
    int d;
    @(posedge sys_clk);
    #1;
    cyc++;
    if (sb_on) begin
      if (exp_q.size() > 0 && exp_q[0] == cyc) begin
        d = exp_q.pop_front();
        check("move_tick", 32'(move_tick), 32'd1);
      end else if (move_tick) begin
        check("spurious_tick", 32'(move_tick), 32'd0);
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    key_start = 1'b1;
    step();
    key_start = 1'b0;
  endtask

  task automatic pulse_restart();
    key_restart = 1'b1;
    step();
    key_restart = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      step();
      n++;
    end while (!move_tick && n < 60);
    check("tick_seen", 32'(move_tick), 32'd1);
  endtask

  initial begin
    int r;
    int p;

    // Reset state
    steps(2);
    check("rst_state", 32'(game_state), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_timer_start", 32'(timer_start), 32'd0);
    check("rst_move_tick", 32'(move_tick), 32'd0);
    sys_rst = 1'b0;
    step();
    check("post_rst_clear", 32'(timer_clear), 32'd1);
    step();
    check("post_rst_clear_end", 32'(timer_clear), 32'd0);

    // Restart wins over start in IDLE; not an IDLE entry, so no clear
    key_start = 1'b1; key_restart = 1'b1;
    step();
    key_start = 1'b0; key_restart = 1'b0;
    check("idle_restart_start", 32'(game_state), 32'd0);
    check("idle_restart_noclear", 32'(timer_clear), 32'd0);

    // Start -> RUN; ticks every 10 clocks
    sb_on = 1'b1;
    pulse_start();
    r = cyc;
    check("start_run", 32'(game_state), 32'd1);
    exp_q.push_back(r + 10);
    exp_q.push_back(r + 20);
    exp_q.push_back(r + 30);
    step();
    check("timer_start_run", 32'(timer_start), 32'd1);
    steps(32);

    // Pause with counter at 3; no ticks, timer stopped
    pulse_start();
    check("pause_state", 32'(game_state), 32'd2);
    steps(20);
    check("pause_timer_start", 32'(timer_start), 32'd0);
    check("pause_state_hold", 32'(game_state), 32'd2);

    // Resume: counter continues from 3, so first tick 7 clocks later
    pulse_start();
    p = cyc;
    check("resume_state", 32'(game_state), 32'd1);
    exp_q.push_back(p + 7);
    exp_q.push_back(p + 17);
    steps(17);
    sb_on = 1'b0;

    // Level ramp: level L shortens tick gap to 10-L clocks
    time_s = 16'd9;
    steps(2);
    check("level_at_9s", 32'(level), 32'd0);
    for (int l = 1; l <= 8; l++) begin
      time_s = 16'(10 * l);
      step();
      check($sformatf("level_%0d", l), 32'(level), 32'(l));
      wait_tick();
      r = cyc;
      sb_on = 1'b1;
      exp_q.push_back(r + (10 - l));
      exp_q.push_back(r + 2 * (10 - l));
      steps(2 * (10 - l));
      sb_on = 1'b0;
    end
    time_s = 16'd90;
    steps(2);
    check("level_saturate", 32'(level), 32'd8);

    // Start and collision together -> OVER
    key_start = 1'b1; collision = 1'b1;
    step();
    key_start = 1'b0; collision = 1'b0;
    check("start_collide_over", 32'(game_state), 32'd3);
    steps(2);
    check("over_timer_start", 32'(timer_start), 32'd0);
    pulse_start();
    check("over_ignore_start", 32'(game_state), 32'd3);
    pulse_restart();
    check("over_restart_idle", 32'(game_state), 32'd0);
    check("restart_clear", 32'(timer_clear), 32'd1);
    check("restart_level", 32'(level), 32'd0);
    step();
    check("restart_clear_end", 32'(timer_clear), 32'd0);

    // Collision ignored in PAUSE
    time_s = 16'd0;
    pulse_start();
    check("run_again", 32'(game_state), 32'd1);
    pulse_start();
    collision = 1'b1;
    step();
    collision = 1'b0;
    check("pause_ignore_collision", 32'(game_state), 32'd2);
    pulse_start();
    check("pause_to_run", 32'(game_state), 32'd1);

    // Timeout at TIME_LIMIT
    time_s = 16'd300;
    step();
`ifdef AUTO_TIMEOUT_EN
    check("timeout_over", 32'(game_state), 32'd3);
`else
    check("timeout_disabled", 32'(game_state), 32'd1);
`endif
    time_s = 16'd0;
    pulse_restart();
    check("restart_after_timeout", 32'(game_state), 32'd0);

    // Restart and collision together in RUN -> IDLE
    pulse_start();
    key_restart = 1'b1; collision = 1'b1;
    step();
    key_restart = 1'b0; collision = 1'b0;
    check("restart_beats_collision", 32'(game_state), 32'd0);

    // Reset mid-RUN at level 5
    pulse_start();
    for (int l = 1; l <= 5; l++) begin
      time_s = 16'(10 * l);
      step();
    end
    check("mid_run_level5", 32'(level), 32'd5);
    sys_rst = 1'b1;
    step();
    check("midrst_state", 32'(game_state), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_move_tick", 32'(move_tick), 32'd0);
    check("midrst_timer_start", 32'(timer_start), 32'd0);
    sys_rst = 1'b0;
    step();
    check("midrst_clear", 32'(timer_clear), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
